// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch PC sequencing, in-flight tracking and decode buffer
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request handshake to instruction memory
//   imem_rsp_valid/data             in-order read responses, one per accepted request
//   redirect_valid/redirect_pc      taken branch/jump
//   exception                       exception taken, target EXC_VECTOR
//   eret/epc                        return from exception
//   inst_valid/ready/data/pc        {pc, instruction} delivery to decode
//   flushing                        high while stale responses are being discarded
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0000,
   parameter int          DEPTH      = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        exception,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        flushing
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
   state_t state;
   logic [31:0] pc;
   logic [AW:0] outst, drop, bcnt, outst_nx;
   logic [AW-1:0] pf_wr, pf_rd, b_wr, b_rd;
   logic [31:0] pf_mem [DEPTH];
   logic [31:0] b_pc [DEPTH];
   logic [31:0] b_data [DEPTH];
   logic acc, redir, keep, pop;
   logic [31:0] target;
   always_comb begin
      imem_req_valid = (state == RUN) && (({1'b0, outst} + {1'b0, bcnt}) < (AW+2)'(DEPTH));
      imem_req_addr = pc;
      acc = imem_req_valid && imem_req_ready;
      redir = eret || exception || redirect_valid;
      target = (eret ? epc : exception ? EXC_VECTOR : redirect_pc) & ~32'h3;
      // a response is kept only when nothing stale is pending and no redirect kills it this cycle
      keep = imem_rsp_valid && !(|drop) && !redir;
      inst_valid = |bcnt;
      pop = inst_valid && inst_ready;
      inst_data = b_data[b_rd];
      inst_pc = b_pc[b_rd];
      flushing = state == FLUSH;
      outst_nx = outst + (AW+1)'(acc) - (AW+1)'(imem_rsp_valid);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
         pc <= RESET_PC;
         outst <= '0;
         drop <= '0;
         bcnt <= '0;
         pf_wr <= '0;
         pf_rd <= '0;
         b_wr <= '0;
         b_rd <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pf_mem[i] <= '0;
            b_pc[i] <= '0;
            b_data[i] <= '0;
         end
      end else begin
         if (acc) begin
            pc <= pc + 32'd4;
            pf_mem[pf_wr] <= pc;
            pf_wr <= pf_wr + AW'(1);
         end
         if (redir) pc <= target;
         // every response, kept or dropped, retires the oldest recorded PC
         if (imem_rsp_valid) pf_rd <= pf_rd + AW'(1);
         outst <= outst_nx;
         if (keep) begin
            b_pc[b_wr] <= pf_mem[pf_rd];
            b_data[b_wr] <= imem_rsp_data;
            b_wr <= b_wr + AW'(1);
         end
         if (redir) begin
            bcnt <= '0;
            b_rd <= b_wr;
         end else begin
            bcnt <= bcnt + (AW+1)'(keep) - (AW+1)'(pop);
            if (pop) b_rd <= b_rd + AW'(1);
         end
         // requests accepted in the redirect cycle are stale too, hence outst_nx
         if (state == RUN && redir) drop <= outst_nx;
         else if (imem_rsp_valid && |drop) drop <= drop - (AW+1)'(1);
         case (state)
            BOOT: state <= RUN;
            RUN: state <= (redir && |outst_nx) ? FLUSH : RUN;
            default: state <= |drop ? FLUSH : RUN;
         endcase
      end
   end
   a_credit: assert property (@(posedge clk) disable iff (!rst_n)
      ({1'b0, outst} + {1'b0, bcnt}) <= (AW+2)'(DEPTH));
   a_rsp: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> |outst);
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed table and sequence checks for fetch_sequencer
module tb_fetch_sequencer;
   logic clk = 0, rst_n = 0;
   logic imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data;
   logic redirect_valid, exception, eret, inst_valid, inst_ready, flushing;
   logic [31:0] redirect_pc, epc, inst_data, inst_pc;
   logic hold;
   logic [31:0] q [$];
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   fetch_sequencer #(.RESET_PC(32'h0), .EXC_VECTOR(32'h80), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .exception(exception), .eret(eret), .epc(epc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
      .flushing(flushing));
   function automatic logic [31:0] f(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C0;
   endfunction
   // memory: answers in order, one cycle after accept unless held
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         imem_rsp_valid <= 1'b0;
         imem_rsp_data <= '0;
      end else begin
         if (imem_rsp_valid) void'(q.pop_front());
         if (imem_req_valid && imem_req_ready) q.push_back(imem_req_addr);
         imem_rsp_valid <= (q.size() != 0) && !hold;
         imem_rsp_data <= (q.size() != 0) ? f(q[0]) : 32'h0;
      end
   end
   typedef struct {
      logic rr, ir, rv;
      logic [31:0] addr;
      logic iv;
      logic [31:0] ipc;
   } vec_t;
   vec_t tbl [19];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic o(input string tag, input logic rv, input logic [31:0] addr, input logic iv,
                    input logic [31:0] ipc, input logic fl);
      chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(rv));
      chk({tag, " req_addr"}, imem_req_addr, addr);
      chk({tag, " flushing"}, 32'(flushing), 32'(fl));
      chk({tag, " inst_valid"}, 32'(inst_valid), 32'(iv));
      if (iv) begin
         chk({tag, " inst_pc"}, inst_pc, ipc);
         chk({tag, " inst_data"}, inst_data, f(ipc));
      end
   endtask
   task automatic clr;
      redirect_valid = 0; redirect_pc = 0; exception = 0; eret = 0; epc = 0;
   endtask
   task automatic do_reset(input logic h);
      rst_n = 0; clr(); hold = h; imem_req_ready = 1; inst_ready = 1;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask
   task automatic cyc;
      @(negedge clk);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      tbl[0]  = '{1, 1, 0, 0,  0, 0};
      tbl[1]  = '{1, 1, 1, 0,  0, 0};
      tbl[2]  = '{1, 1, 1, 4,  0, 0};
      tbl[3]  = '{1, 1, 0, 8,  1, 0};
      tbl[4]  = '{1, 1, 1, 8,  1, 4};
      tbl[5]  = '{1, 1, 1, 12, 0, 0};
      tbl[6]  = '{1, 1, 0, 16, 1, 8};
      tbl[7]  = '{1, 0, 1, 16, 1, 12};
      tbl[8]  = '{1, 0, 0, 20, 1, 12};
      tbl[9]  = '{1, 0, 0, 20, 1, 12};
      tbl[10] = '{1, 1, 0, 20, 1, 12};
      tbl[11] = '{1, 1, 1, 20, 1, 16};
      tbl[12] = '{1, 1, 1, 24, 0, 0};
      tbl[13] = '{1, 1, 0, 28, 1, 20};
      tbl[14] = '{0, 1, 1, 28, 1, 24};
      tbl[15] = '{0, 1, 1, 28, 0, 0};
      tbl[16] = '{1, 1, 1, 28, 0, 0};
      tbl[17] = '{1, 1, 1, 32, 0, 0};
      tbl[18] = '{1, 1, 0, 36, 1, 28};
      clr(); hold = 0; imem_req_ready = 0; inst_ready = 0;
      #1;
      o("reset", 0, 32'h0, 0, 0, 0);
      chk("reset inst_pc", inst_pc, 32'h0);
      chk("reset inst_data", inst_data, 32'h0);
      // stream, decode backpressure and request backpressure
      do_reset(0);
      for (int i = 0; i < 19; i++) begin
         imem_req_ready = tbl[i].rr;
         inst_ready = tbl[i].ir;
         o($sformatf("vec%0d", i), tbl[i].rv, tbl[i].addr, tbl[i].iv, tbl[i].ipc, 0);
         cyc();
      end
      // branch with two requests in flight
      do_reset(1);
      cyc(); o("br c1", 1, 32'h0, 0, 0, 0);
      cyc(); o("br c2", 1, 32'h4, 0, 0, 0);
      cyc(); o("br c3", 0, 32'h8, 0, 0, 0);
      redirect_valid = 1; redirect_pc = 32'h100;
      cyc(); clr(); o("br c4", 0, 32'h100, 0, 0, 1);
      hold = 0;
      cyc(); o("br c5", 0, 32'h100, 0, 0, 1);
      cyc(); o("br c6", 0, 32'h100, 0, 0, 1);
      cyc(); o("br c7", 0, 32'h100, 0, 0, 1);
      cyc(); o("br c8", 1, 32'h100, 0, 0, 0);
      cyc(); o("br c9", 1, 32'h104, 0, 0, 0);
      cyc(); o("br c10", 0, 32'h108, 1, 32'h100, 0);
      // eret beats exception beats branch, target aligned
      do_reset(1);
      cyc(); o("pri c1", 1, 32'h0, 0, 0, 0);
      cyc(); o("pri c2", 1, 32'h4, 0, 0, 0);
      eret = 1; epc = 32'h2003; exception = 1; redirect_valid = 1; redirect_pc = 32'h300;
      cyc(); clr(); o("pri c3", 0, 32'h2000, 0, 0, 1);
      hold = 0;
      cyc(); o("pri c4", 0, 32'h2000, 0, 0, 1);
      cyc(); o("pri c5", 0, 32'h2000, 0, 0, 1);
      cyc(); o("pri c6", 0, 32'h2000, 0, 0, 1);
      cyc(); o("pri c7", 1, 32'h2000, 0, 0, 0);
      // exception during BOOT goes straight to RUN at the vector
      do_reset(0);
      o("boot c0", 0, 32'h0, 0, 0, 0);
      exception = 1; redirect_valid = 1; redirect_pc = 32'h300;
      cyc(); clr(); o("boot c1", 1, 32'h80, 0, 0, 0);
      // redirect coinciding with accept and response
      do_reset(0);
      cyc(); o("co c1", 1, 32'h0, 0, 0, 0);
      cyc(); o("co c2", 1, 32'h4, 0, 0, 0);
      chk("co c2 rsp_valid", 32'(imem_rsp_valid), 32'h1);
      redirect_valid = 1; redirect_pc = 32'h203;
      cyc(); clr(); o("co c3", 0, 32'h200, 0, 0, 1);
      cyc(); o("co c4", 0, 32'h200, 0, 0, 1);
      cyc(); o("co c5", 1, 32'h200, 0, 0, 0);
      cyc(); o("co c6", 1, 32'h204, 0, 0, 0);
      cyc(); o("co c7", 0, 32'h208, 1, 32'h200, 0);
      // async reset in the middle of a flush
      do_reset(1);
      cyc(); cyc(); cyc();
      redirect_valid = 1; redirect_pc = 32'h100;
      cyc(); clr(); o("rf c4", 0, 32'h100, 0, 0, 1);
      #2 rst_n = 0;
      #1;
      o("rf async", 0, 32'h0, 0, 0, 0);
      chk("rf async inst_pc", inst_pc, 32'h0);
      chk("rf async inst_data", inst_data, 32'h0);
      cyc(); hold = 0; rst_n = 1;
      o("rf c0", 0, 32'h0, 0, 0, 0);
      cyc(); o("rf c1", 1, 32'h0, 0, 0, 0);
      cyc(); o("rf c2", 1, 32'h4, 0, 0, 0);
      cyc(); o("rf c3", 0, 32'h8, 1, 32'h0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the single-issue MIPS-style core.
- Owns the architectural fetch PC register and issues requests to instruction memory over a valid/ready handshake.
- Tracks in-flight reads, pairs each response with its PC, and delivers {pc, instruction} to decode through a small buffer.
- Applies eret, exception and branch/jump redirects, discarding every response fetched down the stale path.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
EXC_VECTOR, 32'h0000_0000, target on exception.
DEPTH, 2, maximum in-flight requests plus buffered instructions (power of two, 2..8).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  read data valid; in order, one per accepted request, latency >=1, no backpressure
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  taken branch/jump from next-PC logic
redirect_pc  in  32  branch/jump target
exception  in  1  exception taken
eret  in  1  return from exception
epc  in  32  exception return address
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes
inst_data  out  32  instruction word
inst_pc  out  32  PC of inst_data
flushing  out  1  high while in FLUSH state

Behaviour:
- Reset (async assert): pc=RESET_PC, state=BOOT, outstanding=0, drop=0, buffer empty. All outputs 0 except imem_req_addr=RESET_PC.
- States:
  - BOOT: one cycle with no request, then RUN.
  - RUN: normal fetch.
  - FLUSH: entered on a redirect while drop>0. No requests are issued. Returns to RUN in the cycle after drop reaches 0.
- Credit rule: imem_req_valid = (state==RUN) && (outstanding + buffer_count < DEPTH). imem_req_addr = pc.
- Request handshake: on imem_req_valid && imem_req_ready, pc <= pc+4 (wraps at 32 bits), push pc into the internal PC FIFO, outstanding++.
- Response: if drop>0, the response is discarded, drop--, outstanding--, and the PC FIFO is popped. Otherwise {PC FIFO head, data} is written to the buffer, outstanding--.
- Decode side: inst_valid = buffer non-empty; inst_data/inst_pc are the buffer head. A pop occurs on inst_valid && inst_ready. Buffer outputs are registered; a response reaches inst_valid one cycle after imem_rsp_valid.
- Redirect priority: eret > exception > redirect_valid. Target is epc, EXC_VECTOR or redirect_pc respectively, with bits[1:0] forced to 0. The lower-priority inputs are ignored in the same cycle.
- On any redirect, in the same clock edge:
  - pc <= target.
  - Buffer flushed; a same-cycle inst_ready pop is irrelevant.
  - drop <= outstanding after this cycle's accept/response updates. A request accepted in the redirect cycle counts as stale. A response arriving in that cycle is discarded and not counted.
  - State <= FLUSH if the new drop>0, else RUN.
- Redirect during FLUSH: pc is retargeted and the flush continues; drop is unchanged apart from normal decrements.
- Redirect during BOOT: pc <= target, state <= RUN next cycle.
- Buffer full while a response arrives cannot occur because of the credit rule. Assertion: outstanding + buffer_count <= DEPTH.
- rsp_valid while outstanding==0 is illegal (assertion).
- Reset mid-operation clears all counters and state immediately. Responses arriving after reset release are illegal.

Test Plan:
- Reset and stream: release rst_n, imem_req_ready=1, latency 1, inst_ready=1 -> request addrs 0,4,8,...; inst_pc 0,4,8 paired with matching data; first inst_valid 3 cycles after reset release.
- Backpressure: DEPTH=2, inst_ready=0 -> exactly 2 requests issued then req_valid=0. Raise inst_ready -> fetch resumes at 8 with no gaps or duplicates.
- Branch with 2 in flight: redirect_pc=0x100 while addrs 0x10 and 0x14 are outstanding -> flushing=1; both responses dropped; next request 0x100; first inst_pc=0x100.
- Simultaneous eret, exception and redirect: epc=0x2003, EXC_VECTOR=0x80 -> next request addr 0x2000; flushing follows outstanding.
- Redirect coinciding with req accept and rsp arrival -> accepted request dropped; arriving response not delivered; drop count correct; no stale inst_valid.
- Async reset asserted mid-FLUSH -> all outputs 0 immediately; fetch restarts at RESET_PC after BOOT.
